// File: rtl/adc_capture_buffer_if.sv
// Host-side bus of the ADC capture buffer: frame write port, channel read port, status flags.
// The slave modport is the buffer; the master modport is the deserialiser/host side.
interface adc_capture_buffer_if #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 14,
    parameter int OUT_W    = 16,
    parameter int ADDR_W   = 13
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*DATA_W-1:0] din;
    logic                       wren;
    logic                       rden;
    logic [1:0]                 bw_bits;
    logic                       clr_flags;
    logic [OUT_W-1:0]           dout;
    logic                       dout_valid;
    logic [CH_W-1:0]            dout_chan;
    logic                       full;
    logic                       empty;
    logic [ADDR_W:0]            count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output din, wren, rden, bw_bits, clr_flags,
        input  dout, dout_valid, dout_chan, full, empty, count, overflow, underflow
    );

    modport slave (
        input  din, wren, rden, bw_bits, clr_flags,
        output dout, dout_valid, dout_chan, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// Frame FIFO for multi-channel ADC samples; frames are unloaded one channel per read, MSB-justified.
// Optional one-shot capture mode (arm/done ports) is enabled by `define CAPTURE_ONESHOT_EN.
module adc_capture_buffer #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 14,
    parameter int OUT_W    = 16,
    parameter int ADDR_W   = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_capture_buffer_if.slave  bus
`ifdef CAPTURE_ONESHOT_EN
    ,
    input  logic                 arm,
    output logic                 done
`endif
);
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int DEPTH_N = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CHANNELS - 1);

    logic [FRAME_W-1:0] mem [DEPTH_N];

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CH_W-1:0]    chan_idx;
    logic [ADDR_W:0]    count_q;
    logic [ADDR_W:0]    count_next;
    logic [OUT_W-1:0]   dout_q;
    logic               dout_valid_q;
    logic [CH_W-1:0]    dout_chan_q;
    logic               overflow_q;
    logic               underflow_q;

    logic               full;
    logic               empty;
    logic               wr_gate;
    logic               wr_ok;
    logic               wr_drop;
    logic               rd_ok;
    logic               rd_miss;
    logic               rd_last;

    logic [FRAME_W-1:0] frame;
    logic [DATA_W-1:0]  sample;
    logic [OUT_W-1:0]   masked;
    logic [OUT_W-1:0]   justified;
    int                 act_w;

`ifdef CAPTURE_ONESHOT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;
    state_t state;

    // Outside CAPTURE, writes are discarded silently (no overflow).
    assign wr_gate = (state == ST_CAPTURE);
`else
    assign wr_gate = 1'b1;
`endif

    // Full is judged on this cycle's count, so a concurrent read never rescues a write at full.
    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign wr_ok   = bus.wren && wr_gate && !full;
    assign wr_drop = bus.wren && wr_gate && full;
    assign rd_ok   = bus.rden && !empty;
    assign rd_miss = bus.rden && empty;
    assign rd_last = rd_ok && (chan_idx == LAST_CH);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        count_next = count_q;
        if (wr_ok && !rd_last) begin
            count_next = count_q + 1'b1;
        end else if (rd_last && !wr_ok) begin
            count_next = count_q - 1'b1;
        end
    end

    always_comb begin
        frame  = mem[rd_ptr];
        sample = frame[chan_idx*DATA_W +: DATA_W];
        act_w  = 8 + 2 * int'(bw_bits_now());
        if (act_w > DATA_W) begin
            act_w = DATA_W;
        end
        masked    = OUT_W'(sample) & ~({OUT_W{1'b1}} << act_w);
        justified = masked << (OUT_W - act_w);
    end

    function automatic logic [1:0] bw_bits_now();
        return bus.bw_bits;
    endfunction

    // NOTE: sample storage is never reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            chan_idx     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_chan_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef CAPTURE_ONESHOT_EN
            state        <= ST_IDLE;
            done         <= 1'b0;
`endif
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            dout_valid_q <= rd_ok;
            if (rd_ok) begin
                dout_q      <= justified;
                dout_chan_q <= chan_idx;
                if (rd_last) begin
                    chan_idx <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    chan_idx <= chan_idx + 1'b1;
                end
            end

            count_q <= count_next;

            // A flag event in the same cycle as clr_flags wins over the clear.
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (rd_miss) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_flags) begin
                underflow_q <= 1'b0;
            end

`ifdef CAPTURE_ONESHOT_EN
            case (state)
                ST_IDLE: begin
                    if (arm && empty) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_ok && count_next == DEPTH) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (count_next == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_chan  = dout_chan_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer (4 channels, 14-bit samples, 16 frames deep).
// A frame-queue model predicts each read; expected samples go through a scoreboard queue.
module tb_adc_capture_buffer;
    localparam int CHANNELS = 4;
    localparam int DATA_W   = 14;
    localparam int OUT_W    = 16;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;

    logic clk;
    logic rst;
    logic arm;
    logic done;

    adc_capture_buffer_if #(
        .CHANNELS(CHANNELS), .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) bus ();

    adc_capture_buffer #(
        .CHANNELS(CHANNELS), .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef CAPTURE_ONESHOT_EN
        ,
        .arm  (arm),
        .done (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model state: stored frames (partly read frame stays at the head), channel cursor, flags.
    logic [55:0] mq [$];
    logic [17:0] sb [$];
    int          mc;
    bit          m_ovf;
    bit          m_unf;
    int          m_st;      // 0 idle, 1 capture, 2 done (one-shot build only)
    logic [1:0]  bw;

    localparam logic [55:0] F1 = {14'h1555, 14'h2AAA, 14'h0001, 14'h3FFF};
    localparam logic [55:0] F2 = {14'h0123, 14'h0456, 14'h0789, 14'h2BCD};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_just(input logic [13:0] s, input logic [1:0] b);
        int w;
        logic [15:0] r;
        w = 8 + 2 * int'(b);
        if (w > DATA_W) w = DATA_W;
        r = '0;
        for (int i = 0; i < w; i++) r[15-i] = s[w-1-i];
        return r;
    endfunction

    function automatic logic [55:0] mkf(input int i);
        logic [55:0] f;
        for (int ch = 0; ch < CHANNELS; ch++)
            f[ch*14 +: 14] = 14'((i * 37 + ch * 1001) ^ 14'h2A55);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus, with the model stepped in the same cycle and outputs checked after it.
    task automatic cycle(input bit w, input bit r, input bit c, input logic [55:0] f);
        bit          full_b, empty_b, wr_allow, exp_valid, acc;
        logic [55:0] head;
        logic [17:0] e;
        full_b   = (mq.size() == DEPTH);
        empty_b  = (mq.size() == 0);
        wr_allow = 1'b1;
`ifdef CAPTURE_ONESHOT_EN
        wr_allow = (m_st == 1);
`endif
        bus.wren      = w;
        bus.rden      = r;
        bus.clr_flags = c;
        bus.din       = f;
        bus.bw_bits   = bw;

        exp_valid = r && !empty_b;
        if (exp_valid) begin
            head = mq[0];
            sb.push_back({ref_just(head[mc*14 +: 14], bw), 2'(mc)});
            mc++;
            if (mc == CHANNELS) begin
                mc = 0;
                void'(mq.pop_front());
            end
        end
        if (r && empty_b) m_unf = 1'b1;
        else if (c) m_unf = 1'b0;
        acc = w && wr_allow && !full_b;
        if (acc) mq.push_back(f);
        if (w && wr_allow && full_b) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
`ifdef CAPTURE_ONESHOT_EN
        case (m_st)
            0: if (arm && empty_b) m_st = 1;
            1: if (acc && mq.size() == DEPTH) m_st = 2;
            default: if (mq.size() == 0) m_st = 0;
        endcase
`endif
        tick();
        bus.wren      = 1'b0;
        bus.rden      = 1'b0;
        bus.clr_flags = 1'b0;

        check("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
        if (exp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("dout", 32'(bus.dout), 32'(e[17:2]));
            check("dout_chan", 32'(bus.dout_chan), 32'(e[1:0]));
        end
    endtask

    task automatic wr(input logic [55:0] f);
        cycle(1'b1, 1'b0, 1'b0, f);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        check({tag, ".full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
`ifdef CAPTURE_ONESHOT_EN
        check({tag, ".done"}, 32'(done), 32'(m_st == 2));
`endif
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.wren      = 1'b0;
        bus.rden      = 1'b0;
        bus.clr_flags = 1'b0;
        arm           = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        sb.delete();
        mc    = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_st  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k1 [4];
        k1[0] = 16'hFFFC; k1[1] = 16'h0004; k1[2] = 16'hAAA8; k1[3] = 16'h5554;
        bw          = 2'b11;
        bus.din     = '0;
        bus.bw_bits = bw;
        do_reset();

        check("rst.dout", 32'(bus.dout), 32'h0);
        check("rst.dout_valid", 32'(bus.dout_valid), 32'h0);
        check("rst.dout_chan", 32'(bus.dout_chan), 32'h0);
        check_status("rst");

`ifndef CAPTURE_ONESHOT_EN
        // Full-width justification of a known frame, count drops only on the last channel.
        wr(F1);
        check_status("t1.wr");
        for (int i = 0; i < 4; i++) begin
            rd();
            check($sformatf("t1.dout%0d", i), 32'(bus.dout), 32'(k1[i]));
            if (i == 2) check_status("t1.rd3");
        end
        check_status("t1.rd4");

        // Narrow sample widths; a bw change applies from the next read.
        wr(F1);
        bw = 2'b00;
        rd();
        check("t2.bw8.ch0", 32'(bus.dout), 32'hFF00);
        rd();
        rd();
        check("t2.bw8.ch2", 32'(bus.dout), 32'hAA00);
        bw = 2'b01;
        rd();
        check("t2.bw10.ch3", 32'(bus.dout), 32'h5540);
        wr(F1);
        rd();
        check("t2.bw10.ch0", 32'(bus.dout), 32'hFFC0);
        bw = 2'b10;
        for (int i = 0; i < 3; i++) rd();
        check_status("t2.end");

        // Fill to full; the 17th write is dropped and sets overflow.
        for (int i = 0; i < 17; i++) begin
            wr(mkf(i));
            if (i == 15) check_status("t3.full");
        end
        check_status("t3.drop");
        cycle(1'b0, 1'b0, 1'b1, '0);
        check_status("t3.clr");

        // Write at full concurrent with a last-channel read is still dropped.
        for (int i = 0; i < 3; i++) rd();
        cycle(1'b1, 1'b1, 1'b0, mkf(99));
        check_status("t4.wr_rd_full");
        for (int i = 0; i < 60; i++) rd();
        check_status("t4.drained");
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Underflow on an empty read; a same-cycle write is not yet readable.
        rd();
        check_status("t5.unf");
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b0, F2);
        check_status("t5.wr_rd_empty");
        for (int i = 0; i < 4; i++) rd();
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Reset mid-frame discards the partly read frame.
        bw = 2'b11;
        wr(F1);
        rd();
        rd();
        do_reset();
        check_status("t5.rst_mid");
        check("t5.rst_mid.dout", 32'(bus.dout), 32'h0);
        wr(F2);
        rd();
        check("t5.after_rst.chan", 32'(bus.dout_chan), 32'h0);
        check("t5.after_rst.dout", 32'(bus.dout), 32'hAF34);
        rd();
        check_status("t5.end");
`else
        // One-shot: ignored before arm, stops at full, returns to idle when drained.
        wr(F1);
        wr(F1);
        check_status("t6.pre_arm");
        arm = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, '0);
        arm = 1'b0;
        for (int i = 0; i < 20; i++) wr(mkf(i));
        check_status("t6.captured");
        for (int i = 0; i < 64; i++) rd();
        check_status("t6.drained");
        wr(F2);
        check_status("t6.idle_again");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
